mem_fill_arbiter: RTL and testbench

//  Shares the single-ported, multi-cycle main memory between the I-cache and D-cache
//  of the pipelined WISC core. Arbitrates D-side store write-through and D/I miss fills.

---
 rtl/mem_fill_arbiter_pkg.sv | 29 ++
 rtl/mem_fill_arbiter_word_cnt.sv | 27 ++
 rtl/mem_fill_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_fill_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_fill_arbiter_pkg.sv
// Shared definitions for the memory fill arbiter.
// Holds the bus widths, block geometry, FSM state codes, fill owner encoding
// and the helper that aligns an address down to its cache block base.
package mem_fill_arbiter_pkg;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned WORDS    = 8;
  localparam int unsigned OFFSET_W = 3;
  localparam int unsigned MEM_LAT  = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StFill  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OwnerNone = 2'd0,
    OwnerI    = 2'd1,
    OwnerD    = 2'd2
  } owner_e;

  // Clear the word offset and byte-select bits: {addr[15:4], 4'b0}.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W+1], {(OFFSET_W+1){1'b0}}};
  endfunction

endpackage

// File: rtl/mem_fill_arbiter_word_cnt.sv
// Block word counter.
// 3-bit up counter with synchronous reset, synchronous clear and count enable.
// Used once to step the fill issue address and once to tag returning words.
// Ports: clk, rst (sync, active-high), clr (sync clear), en (increment), cnt (current value).
module mem_fill_arbiter_word_cnt
  import mem_fill_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  output logic [OFFSET_W-1:0] cnt
);

  logic [OFFSET_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + OFFSET_W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_fill_arbiter.sv
// Memory fill arbiter.
// Shares the single-ported, multi-cycle main memory between the I-cache and D-cache.
// Grants in IDLE only with fixed priority d_wr_req > d_miss > i_miss and never preempts.
// A store is a single write cycle; a miss becomes an 8-word block fill whose reads are
// issued back to back and whose returning words are steered to the owning cache.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   i_miss/i_miss_addr               I-side fill request (held until i_fill_done)
//   d_miss/d_miss_addr               D-side fill request (held until d_fill_done)
//   d_wr_req/d_wr_addr/d_wr_data     D-side store write-through (held until d_wr_done)
//   mem_en/mem_wr/mem_addr/mem_wdata memory command
//   mem_rdata/mem_rvalid             memory read return (MEM_LAT cycles after issue)
//   fill_data/fill_word              word and offset written into the owning cache
//   i_fill_we/d_fill_we              data-array write enables
//   i_tag_we/d_tag_we                tag/valid write pulses on the last word
//   i_fill_done/d_fill_done          fill complete pulses
//   d_wr_done                        store accepted pulse
//   busy                             arbiter not idle
module mem_fill_arbiter
  import mem_fill_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_miss,
  input  logic [ADDR_W-1:0]   i_miss_addr,
  input  logic                d_miss,
  input  logic [ADDR_W-1:0]   d_miss_addr,
  input  logic                d_wr_req,
  input  logic [ADDR_W-1:0]   d_wr_addr,
  input  logic [DATA_W-1:0]   d_wr_data,
  output logic                mem_en,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rvalid,
  output logic [DATA_W-1:0]   fill_data,
  output logic [OFFSET_W-1:0] fill_word,
  output logic                i_fill_we,
  output logic                d_fill_we,
  output logic                i_tag_we,
  output logic                d_tag_we,
  output logic                i_fill_done,
  output logic                d_fill_done,
  output logic                d_wr_done,
  output logic                busy
);

  state_e              state_q;
  owner_e              owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  // Set once the 8th read has been issued; the 3-bit issue counter wraps to 0.
  logic                issue_done_q;

  logic [OFFSET_W-1:0] issue_cnt;
  logic [OFFSET_W-1:0] recv_cnt;
  logic                in_fill;
  logic                issuing;
  logic                beat;
  logic                last_beat;

  assign in_fill   = (state_q == StFill);
  assign issuing   = in_fill && !issue_done_q;
  // rvalid outside FILL (stray or left over from a reset fill) is ignored.
  assign beat      = in_fill && mem_rvalid;
  assign last_beat = beat && (recv_cnt == OFFSET_W'(WORDS - 1));

  mem_fill_arbiter_word_cnt u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!in_fill),
    .en  (issuing),
    .cnt (issue_cnt)
  );

  mem_fill_arbiter_word_cnt u_recv_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!in_fill),
    .en  (beat),
    .cnt (recv_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= OwnerNone;
      addr_q       <= '0;
      wdata_q      <= '0;
      issue_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          issue_done_q <= 1'b0;
          if (d_wr_req) begin
            state_q <= StWrite;
            addr_q  <= d_wr_addr;
            wdata_q <= d_wr_data;
          end else if (d_miss) begin
            state_q <= StFill;
            owner_q <= OwnerD;
            addr_q  <= block_base(d_miss_addr);
          end else if (i_miss) begin
            state_q <= StFill;
            owner_q <= OwnerI;
            addr_q  <= block_base(i_miss_addr);
          end
        end
        StWrite: begin
          state_q <= StIdle;
        end
        StFill: begin
          if (issuing && (issue_cnt == OFFSET_W'(WORDS - 1))) begin
            issue_done_q <= 1'b1;
          end
          if (last_beat) begin
            state_q      <= StIdle;
            owner_q      <= OwnerNone;
            issue_done_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_data   = '0;
    fill_word   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_tag_we    = 1'b0;
    d_tag_we    = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_done   = 1'b0;
    unique case (state_q)
      StWrite: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        d_wr_done = 1'b1;
      end
      StFill: begin
        if (issuing) begin
          mem_en   = 1'b1;
          mem_addr = {addr_q[ADDR_W-1:OFFSET_W+1], issue_cnt, 1'b0};
        end
        if (beat) begin
          fill_data   = mem_rdata;
          fill_word   = recv_cnt;
          i_fill_we   = (owner_q == OwnerI);
          d_fill_we   = (owner_q == OwnerD);
          i_tag_we    = last_beat && (owner_q == OwnerI);
          d_tag_we    = last_beat && (owner_q == OwnerD);
          i_fill_done = last_beat && (owner_q == OwnerI);
          d_fill_done = last_beat && (owner_q == OwnerD);
        end
      end
      default: ;
    endcase
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
module tb_mem_fill_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss, d_miss, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvalid;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_tag_we, d_tag_we;
  logic        i_fill_done, d_fill_done, d_wr_done, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_fill_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .i_miss      (i_miss),
    .i_miss_addr (i_miss_addr),
    .d_miss      (d_miss),
    .d_miss_addr (d_miss_addr),
    .d_wr_req    (d_wr_req),
    .d_wr_addr   (d_wr_addr),
    .d_wr_data   (d_wr_data),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .fill_data   (fill_data),
    .fill_word   (fill_word),
    .i_fill_we   (i_fill_we),
    .d_fill_we   (d_fill_we),
    .i_tag_we    (i_tag_we),
    .d_tag_we    (d_tag_we),
    .i_fill_done (i_fill_done),
    .d_fill_done (d_fill_done),
    .d_wr_done   (d_wr_done),
    .busy        (busy)
  );

  // Memory model: pipelined reads, data returned 4 cycles after issue.
  logic [3:0]  rv_pipe = '0;
  logic [15:0] ra_pipe [4];
  logic        stray_rv = 1'b0;

  always @(posedge clk) begin
    rv_pipe    <= {rv_pipe[2:0], mem_en && !mem_wr};
    ra_pipe[0] <= mem_addr;
    for (int i = 1; i < 4; i++) ra_pipe[i] <= ra_pipe[i-1];
  end

  assign mem_rvalid = rv_pipe[3] | stray_rv;
  assign mem_rdata  = rv_pipe[3] ? (ra_pipe[3] ^ 16'hA5A5) : 16'h5A5A;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mem_exp_t;

  typedef struct packed {
    logic        side_d;
    logic [2:0]  word;
    logic [15:0] data;
    logic        last;
  } fill_exp_t;

  mem_exp_t  mem_q[$];
  fill_exp_t fill_q[$];
  logic      mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected traffic for a fill: n_iss reads issued, n_beat words returned.
  task automatic push_fill(input logic side_d, input logic [15:0] addr,
                           input int n_iss, input int n_beat);
    logic [15:0] base;
    logic [15:0] a;
    base = {addr[15:4], 4'h0};
    for (int k = 0; k < n_iss; k++) begin
      a = base + 16'(2 * k);
      mem_q.push_back('{wr: 1'b0, addr: a, wdata: 16'h0});
    end
    for (int k = 0; k < n_beat; k++) begin
      a = base + 16'(2 * k);
      fill_q.push_back('{side_d: side_d, word: 3'(k), data: a ^ 16'hA5A5, last: (k == 7)});
    end
  endtask

  task automatic push_write(input logic [15:0] addr, input logic [15:0] data);
    mem_q.push_back('{wr: 1'b1, addr: addr, wdata: data});
  endtask

  // Monitor: samples settled outputs 2 time units after each falling edge.
  always @(negedge clk) begin
    mem_exp_t  me;
    fill_exp_t fe;
    #2;
    if (mon_on) begin
      if (mem_en) begin
        if (mem_q.size() == 0) begin
          chk("mem_unexpected", {15'h0, mem_wr, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          me = mem_q.pop_front();
          chk("mem_wr", 32'(mem_wr), 32'(me.wr));
          chk("mem_addr", 32'(mem_addr), 32'(me.addr));
          if (me.wr) chk("mem_wdata", 32'(mem_wdata), 32'(me.wdata));
          chk("d_wr_done_on_cmd", 32'(d_wr_done), 32'(me.wr));
        end
      end else begin
        chk("idle_bus", {15'h0, d_wr_done, mem_addr}, 32'h0);
      end
      if (i_fill_we || d_fill_we) begin
        if (fill_q.size() == 0) begin
          chk("fill_unexpected", {28'h0, fill_word, d_fill_we}, 32'hFFFF_FFFF);
        end else begin
          fe = fill_q.pop_front();
          chk("fill_we_side", {30'h0, i_fill_we, d_fill_we}, {30'h0, !fe.side_d, fe.side_d});
          chk("fill_word", 32'(fill_word), 32'(fe.word));
          chk("fill_data", 32'(fill_data), 32'(fe.data));
          chk("tag_done", {28'h0, i_tag_we, i_fill_done, d_tag_we, d_fill_done},
              fe.side_d ? {28'h0, 2'b00, fe.last, fe.last} : {28'h0, fe.last, fe.last, 2'b00});
        end
      end else begin
        chk("pulse_without_beat", {28'h0, i_tag_we, i_fill_done, d_tag_we, d_fill_done}, 32'h0);
      end
    end
  end

  // Runs until all requests were answered and the arbiter is idle again.
  // Cycle numbers count falling edges after the grant edge (cycle 1 = first cycle after it).
  task automatic run(input int budget, output int end_cyc, output int first_en,
                     output int wr_cyc, output int d_cyc, output int i_cyc);
    int n;
    n = 0;
    first_en = -1; wr_cyc = -1; d_cyc = -1; i_cyc = -1;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (mem_en && first_en < 0) first_en = n;
      if (d_wr_done)   begin wr_cyc = n; d_wr_req = 1'b0; end
      if (d_fill_done) begin d_cyc  = n; d_miss   = 1'b0; end
      if (i_fill_done) begin i_cyc  = n; i_miss   = 1'b0; end
      if (!i_miss && !d_miss && !d_wr_req && !busy) break;
    end
    end_cyc = n;
    if (n >= budget) chk("run_timeout", 32'(n), 32'(budget - 1));
  endtask

  int e, f, w, dc, ic;

  initial begin
    rst = 1'b1;
    i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
    i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, mem_en, mem_wr, i_fill_we, d_fill_we, i_tag_we, d_tag_we,
        i_fill_done, d_fill_done, d_wr_done, fill_word}, 32'h0);
    chk("reset_buses", {mem_addr, mem_wdata | fill_data}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    mon_on = 1'b1;

    // I-miss fill: issues cycles 1..8, done at 12.
    push_fill(1'b0, 16'h1236, 8, 8);
    i_miss = 1'b1; i_miss_addr = 16'h1236;
    run(60, e, f, w, dc, ic);
    chk("i_first_issue", 32'(f), 32'd1);
    chk("i_done_cycle", 32'(ic), 32'd12);
    chk("i_idle_cycle", 32'(e), 32'd13);
    chk("i_no_d_done", 32'(dc), 32'hFFFF_FFFF);

    // Store write-through: one cycle, idle the next.
    push_write(16'h0040, 16'hBEEF);
    d_wr_req = 1'b1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF;
    run(20, e, f, w, dc, ic);
    chk("wr_done_cycle", 32'(w), 32'd1);
    chk("wr_idle_cycle", 32'(e), 32'd2);

    // Simultaneous I and D miss: D first, I granted the cycle after d_fill_done.
    push_fill(1'b1, 16'h3008, 8, 8);
    push_fill(1'b0, 16'h2000, 8, 8);
    i_miss = 1'b1; i_miss_addr = 16'h2000;
    d_miss = 1'b1; d_miss_addr = 16'h3008;
    run(80, e, f, w, dc, ic);
    chk("id_d_done", 32'(dc), 32'd12);
    chk("id_i_done", 32'(ic), 32'd25);
    chk("id_idle", 32'(e), 32'd26);

    // Store + D miss + I miss: write, then D fill, then I fill.
    push_write(16'h0100, 16'h1234);
    push_fill(1'b1, 16'h0208, 8, 8);
    push_fill(1'b0, 16'h0316, 8, 8);
    d_wr_req = 1'b1; d_wr_addr = 16'h0100; d_wr_data = 16'h1234;
    d_miss = 1'b1; d_miss_addr = 16'h0208;
    i_miss = 1'b1; i_miss_addr = 16'h0316;
    run(80, e, f, w, dc, ic);
    chk("wdi_wr_done", 32'(w), 32'd1);
    chk("wdi_d_done", 32'(dc), 32'd14);
    chk("wdi_i_done", 32'(ic), 32'd27);

    // Reset asserted in cycle 6 of a fill: 6 reads issued, only words 0,1 delivered.
    push_fill(1'b0, 16'h4000, 6, 2);
    i_miss = 1'b1; i_miss_addr = 16'h4000;
    repeat (6) @(negedge clk);
    rst = 1'b1; i_miss = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rst_quiet", {26'h0, busy, i_fill_we, i_tag_we, i_fill_done, d_fill_we, d_fill_done},
          32'h0);
    end

    // Stray rvalid while idle.
    stray_rv = 1'b1;
    #1;
    chk("stray_no_we", {30'h0, i_fill_we, d_fill_we}, 32'h0);
    @(negedge clk);
    stray_rv = 1'b0;

    // I miss dropped mid-fill: fill still completes from word 0.
    push_fill(1'b0, 16'h5A5E, 8, 8);
    i_miss = 1'b1; i_miss_addr = 16'h5A5E;
    repeat (3) @(negedge clk);
    i_miss = 1'b0;
    run(40, e, f, w, dc, ic);
    chk("drop_done", 32'(ic), 32'd9);

    repeat (4) @(negedge clk);
    chk("mem_q_left", 32'(mem_q.size()), 32'd0);
    chk("fill_q_left", 32'(fill_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
